controller_sequencer: RTL

CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

---
 rtl/controller_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/controller_sequencer.sv
// Purpose : T-state sequencer for a small accumulator CPU; decodes bus-drive and load strobes from the state and the IR opcode.
// Latency : controls are combinational from the current state and ir_in; the state advances one T-state per rising clk with step_en=1.
// Backpressure: step_en=0 freezes the state and suppresses all load/increment strobes; bus drives stay visible.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, forces T1 (overrides step_en and HALT)
//   step_en  advance enable
//   ir_in    instruction register, opcode = ir_in[INSTR_WIDTH-1 -: 4]
//   pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
//   a_load, a_out, b_load, out_load, alu_sub, alu_out   control strobes
//   t_state  one-hot T-state (bit0 = T1), all zero in HALT
//   halted   high while in HALT
//
// Optional feature macro: CTRL_EARLY_FINISH_EN
//   When defined, idle trailing T-states are skipped: NOP returns T3->T1,
//   OUT returns T4->T1, LDA returns T5->T1. ADD/SUB/HLT timing is unchanged.

module controller_sequencer #(
  parameter int INSTR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step_en,
  input  logic [INSTR_WIDTH-1:0] ir_in,
  output logic                   pc_inc,
  output logic                   pc_out,
  output logic                   mar_load,
  output logic                   ram_out,
  output logic                   ir_load,
  output logic                   ir_out,
  output logic                   a_load,
  output logic                   a_out,
  output logic                   b_load,
  output logic                   out_load,
  output logic                   alu_sub,
  output logic                   alu_out,
  output logic [5:0]             t_state,
  output logic                   halted
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  state_e     state_q;
  state_e     state_d;
  logic [3:0] opcode;
  logic       is_nop;

  assign opcode = ir_in[INSTR_WIDTH-1 -: 4];

  // Operand bits are not needed by the sequencer itself.
  generate
    if (INSTR_WIDTH > 4) begin : g_operand
      logic unused_operand;
      assign unused_operand = ^ir_in[INSTR_WIDTH-5:0];
    end
  endgenerate

  always_comb begin
    is_nop = 1'b1;
    case (opcode)
      OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT: is_nop = 1'b0;
      default:                                is_nop = 1'b1;
    endcase
  end

  // Next-state logic. Holding when step_en is low is folded in here so the
  // state register only has to choose between reset and state_d.
  always_comb begin
    state_d = state_q;
    if (step_en) begin
      case (state_q)
        S_T1: state_d = S_T2;
        S_T2: state_d = S_T3;
        S_T3: begin
`ifdef CTRL_EARLY_FINISH_EN
          state_d = is_nop ? S_T1 : S_T4;
`else
          state_d = S_T4;
`endif
        end
        S_T4: begin
          if (opcode == OP_HLT) begin
            state_d = S_HALT;
          end else begin
`ifdef CTRL_EARLY_FINISH_EN
            state_d = (opcode == OP_OUT) ? S_T1 : S_T5;
`else
            state_d = S_T5;
`endif
          end
        end
        S_T5: begin
`ifdef CTRL_EARLY_FINISH_EN
          state_d = (opcode == OP_LDA) ? S_T1 : S_T6;
`else
          state_d = S_T6;
`endif
        end
        S_T6:    state_d = S_T1;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_T1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_T1;
    end else begin
      state_q <= state_d;
    end
  end

  // Raw strobes before step_en gating. Only load/increment strobes are gated
  // so a stalled cycle never commits anything, while the bus keeps its value.
  logic pc_inc_raw;
  logic mar_load_raw;
  logic ir_load_raw;
  logic a_load_raw;
  logic b_load_raw;
  logic out_load_raw;

  always_comb begin
    pc_inc_raw   = 1'b0;
    mar_load_raw = 1'b0;
    ir_load_raw  = 1'b0;
    a_load_raw   = 1'b0;
    b_load_raw   = 1'b0;
    out_load_raw = 1'b0;
    pc_out       = 1'b0;
    ram_out      = 1'b0;
    ir_out       = 1'b0;
    a_out        = 1'b0;
    alu_out      = 1'b0;
    alu_sub      = 1'b0;
    t_state      = 6'b000000;
    halted       = 1'b0;
    case (state_q)
      S_T1: begin
        t_state      = 6'b000001;
        pc_out       = 1'b1;
        mar_load_raw = 1'b1;
      end
      S_T2: begin
        t_state    = 6'b000010;
        pc_inc_raw = 1'b1;
      end
      S_T3: begin
        t_state     = 6'b000100;
        ram_out     = 1'b1;
        ir_load_raw = 1'b1;
      end
      S_T4: begin
        t_state = 6'b001000;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ir_out       = 1'b1;
            mar_load_raw = 1'b1;
          end
          OP_OUT: begin
            a_out        = 1'b1;
            out_load_raw = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        t_state = 6'b010000;
        case (opcode)
          OP_LDA: begin
            ram_out    = 1'b1;
            a_load_raw = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ram_out    = 1'b1;
            b_load_raw = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        t_state = 6'b100000;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          alu_out    = 1'b1;
          a_load_raw = 1'b1;
          alu_sub    = (opcode == OP_SUB);
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_inc   = pc_inc_raw   & step_en;
  assign mar_load = mar_load_raw & step_en;
  assign ir_load  = ir_load_raw  & step_en;
  assign a_load   = a_load_raw   & step_en;
  assign b_load   = b_load_raw   & step_en;
  assign out_load = out_load_raw & step_en;

endmodule
